// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encodings and stall-vector helpers for the
// pipeline controller of the 6-stage core (pc, ic, id, ex, mem, wb).
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // A stall from stage k freezes stages 0..k; stage k+1 receives a bubble.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IC   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    PC_RUN        = 2'd0,
    PC_WAIT_REDIR = 2'd1,
    PC_EXCP       = 2'd2,
    PC_FLUSH      = 2'd3
  } pc_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_IC   = 3'd1,
    CAUSE_ID   = 3'd2,
    CAUSE_EX   = 3'd3,
    CAUSE_MEM  = 3'd4
  } stall_cause_e;

  // The deepest requesting stage wins; shallower requests are covered by it.
  function automatic stall_cause_e stall_winner(input logic ic, input logic id,
                                                input logic ex, input logic mem);
    stall_cause_e c;
    if (mem)     c = CAUSE_MEM;
    else if (ex) c = CAUSE_EX;
    else if (id) c = CAUSE_ID;
    else if (ic) c = CAUSE_IC;
    else         c = CAUSE_NONE;
    return c;
  endfunction

  function automatic logic [STALL_W-1:0] stall_vec(input stall_cause_e c);
    logic [STALL_W-1:0] v;
    case (c)
      CAUSE_MEM: v = STALL_MEM;
      CAUSE_EX:  v = STALL_EX;
      CAUSE_ID:  v = STALL_ID;
      CAUSE_IC:  v = STALL_IC;
      default:   v = STALL_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stage requests and controller outputs. The pipeline side
// (stages, testbench) uses master; the controller uses slave.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) ();

  logic               stallreq_ic;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic               br_e;
  logic [PC_W-1:0]    br_target;
  logic               excp_valid;
  logic [PC_W-1:0]    excp_pc;
  logic               cnt_clr;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [CNT_W-1:0]   cnt_ic;
  logic [CNT_W-1:0]   cnt_id;
  logic [CNT_W-1:0]   cnt_ex;
  logic [CNT_W-1:0]   cnt_mem;

  modport master (
    output stallreq_ic, stallreq_id, stallreq_ex, stallreq_mem,
    output br_e, br_target, excp_valid, excp_pc, cnt_clr,
    input  stall, flush, redirect_valid, redirect_pc,
    input  cnt_ic, cnt_id, cnt_ex, cnt_mem
  );

  modport slave (
    input  stallreq_ic, stallreq_id, stallreq_ex, stallreq_mem,
    input  br_e, br_target, excp_valid, excp_pc, cnt_clr,
    output stall, flush, redirect_valid, redirect_pc,
    output cnt_ic, cnt_id, cnt_ex, cnt_mem
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module pipe_ctrl_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Count up, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests into the stall bus, issues
// zero-latency branch redirects (deferred while the PC stage is held), and
// sequences exception freeze -> flush + redirect. Stall and redirect must
// react in the same cycle as their requests, so those paths are
// combinational from registered state; flush comes straight from the state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       resetn,
  pipe_ctrl_if.slave ctrl
);

  pc_state_e          r_state;
  logic [PC_W-1:0]    r_pending;
  logic [PC_W-1:0]    r_excp_pc;
  logic [PC_W-1:0]    r_redirect_pc;

  stall_cause_e       w_cause;
  logic [STALL_W-1:0] w_stall_norm;
  logic [STALL_W-1:0] w_stall;
  logic               w_fire;
  logic [PC_W-1:0]    w_target;
  logic               w_cnt_en;
  logic [CNT_W-1:0]   w_cnt_ic;
  logic [CNT_W-1:0]   w_cnt_id;
  logic [CNT_W-1:0]   w_cnt_ex;
  logic [CNT_W-1:0]   w_cnt_mem;

  assign w_cause      = stall_winner(ctrl.stallreq_ic, ctrl.stallreq_id,
                                     ctrl.stallreq_ex, ctrl.stallreq_mem);
  assign w_stall_norm = stall_vec(w_cause);

  // Per-state stall vector and redirect decision for the current cycle.
  always_comb begin
    w_stall  = w_stall_norm;
    w_fire   = 1'b0;
    w_target = r_redirect_pc;
    w_cnt_en = 1'b0;
    case (r_state)
      PC_RUN: begin
        w_cnt_en = 1'b1;
        if (ctrl.excp_valid) begin
          w_stall = STALL_ALL;
        end else if (ctrl.br_e && (w_stall_norm[0] == NO_STOP)) begin
          w_fire   = 1'b1;
          w_target = ctrl.br_target;
        end else begin
          w_fire = 1'b0;
        end
      end
      PC_WAIT_REDIR: begin
        w_cnt_en = 1'b1;
        if (ctrl.excp_valid) begin
          w_stall = STALL_ALL;
        end else if (w_stall_norm[0] == NO_STOP) begin
          w_fire   = 1'b1;
          w_target = r_pending;
        end else begin
          w_fire = 1'b0;
        end
      end
      PC_EXCP: begin
        // Keep the pipe frozen until the flush cycle.
        w_stall = STALL_ALL;
      end
      PC_FLUSH: begin
        w_stall  = STALL_NONE;
        w_fire   = 1'b1;
        w_target = r_excp_pc;
      end
      default: begin
        w_stall = STALL_NONE;
      end
    endcase
  end

  // Controller FSM plus the latched branch/exception targets and last redirect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= PC_RUN;
      r_pending     <= {PC_W{1'b0}};
      r_excp_pc     <= {PC_W{1'b0}};
      r_redirect_pc <= {PC_W{1'b0}};
    end else begin
      if (w_fire) begin
        r_redirect_pc <= w_target;
      end else begin
        r_redirect_pc <= r_redirect_pc;
      end
      case (r_state)
        PC_RUN: begin
          if (ctrl.excp_valid) begin
            r_excp_pc <= ctrl.excp_pc;
            r_state   <= PC_EXCP;
          end else if (ctrl.br_e && (w_stall_norm[0] == STOP)) begin
            r_pending <= ctrl.br_target;
            r_state   <= PC_WAIT_REDIR;
          end else begin
            r_state <= PC_RUN;
          end
        end
        PC_WAIT_REDIR: begin
          if (ctrl.excp_valid) begin
            r_excp_pc <= ctrl.excp_pc;
            r_pending <= {PC_W{1'b0}};
            r_state   <= PC_EXCP;
          end else if (w_stall_norm[0] == NO_STOP) begin
            r_state <= PC_RUN;
          end else begin
            r_state <= PC_WAIT_REDIR;
          end
        end
        PC_EXCP:  r_state <= PC_FLUSH;
        PC_FLUSH: r_state <= PC_RUN;
        default:  r_state <= PC_RUN;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted, even with requests present.
  assign ctrl.stall          = resetn ? w_stall : STALL_NONE;
  assign ctrl.flush          = (r_state == PC_FLUSH);
  assign ctrl.redirect_valid = w_fire & resetn;
  assign ctrl.redirect_pc    = (w_fire & resetn) ? w_target : r_redirect_pc;

  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_ic (
    .clk(clk), .resetn(resetn), .i_clr(ctrl.cnt_clr),
    .i_inc(w_cnt_en && (w_cause == CAUSE_IC)), .o_cnt(w_cnt_ic)
  );
  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_id (
    .clk(clk), .resetn(resetn), .i_clr(ctrl.cnt_clr),
    .i_inc(w_cnt_en && (w_cause == CAUSE_ID)), .o_cnt(w_cnt_id)
  );
  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_ex (
    .clk(clk), .resetn(resetn), .i_clr(ctrl.cnt_clr),
    .i_inc(w_cnt_en && (w_cause == CAUSE_EX)), .o_cnt(w_cnt_ex)
  );
  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_mem (
    .clk(clk), .resetn(resetn), .i_clr(ctrl.cnt_clr),
    .i_inc(w_cnt_en && (w_cause == CAUSE_MEM)), .o_cnt(w_cnt_mem)
  );

  assign ctrl.cnt_ic  = w_cnt_ic;
  assign ctrl.cnt_id  = w_cnt_id;
  assign ctrl.cnt_ex  = w_cnt_ex;
  assign ctrl.cnt_mem = w_cnt_mem;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Expected redirect targets are queued
// when the causing stimulus is driven and popped by a monitor whenever the
// controller raises redirect_valid.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int PW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [PW-1:0] exp_redir_q[$];

  pipe_ctrl_if #(.PC_W(PW), .CNT_W(CW)) ifc ();

  pipe_ctrl #(.PC_W(PW), .CNT_W(CW)) dut (
    .clk(clk),
    .resetn(resetn),
    .ctrl(ifc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.stallreq_ic  = 1'b0;
    ifc.stallreq_id  = 1'b0;
    ifc.stallreq_ex  = 1'b0;
    ifc.stallreq_mem = 1'b0;
    ifc.br_e         = 1'b0;
    ifc.br_target    = 32'h0;
    ifc.excp_valid   = 1'b0;
    ifc.excp_pc      = 32'h0;
    ifc.cnt_clr      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Redirect scoreboard: every pulse must match the oldest expected target.
  always @(negedge clk) begin
    if (resetn && ifc.redirect_valid) begin
      if (exp_redir_q.size() == 0) begin
        check_eq("redir_unexpected", {63'd0, ifc.redirect_valid}, 64'd0);
      end else begin
        check_eq("redir_pc", ifc.redirect_pc, exp_redir_q.pop_front());
      end
    end
  end

  initial begin
    idle();
    #1;
    check_eq("rst_stall", ifc.stall, 64'h0);
    check_eq("rst_flush", ifc.flush, 64'h0);
    check_eq("rst_rv", ifc.redirect_valid, 64'h0);
    check_eq("rst_rpc", ifc.redirect_pc, 64'h0);
    check_eq("rst_cnt_mem", ifc.cnt_mem, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: id and mem together -> mem wins, only mem counted
    ifc.stallreq_id  = 1'b1;
    ifc.stallreq_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t1_stall", ifc.stall, 64'h1F);
      next_cycle();
    end
    idle();
    sample();
    check_eq("t1_cnt_mem", ifc.cnt_mem, 64'd3);
    check_eq("t1_cnt_id", ifc.cnt_id, 64'd0);
    ifc.cnt_clr = 1'b1;
    next_cycle();
    ifc.cnt_clr = 1'b0;
    sample();
    check_eq("t1_clr", ifc.cnt_mem, 64'd0);
    next_cycle();

    // 2: unstalled branch -> same-cycle redirect, single pulse
    ifc.br_e      = 1'b1;
    ifc.br_target = 32'hBFC0_0100;
    exp_redir_q.push_back(32'hBFC0_0100);
    sample();
    check_eq("t2_rv", ifc.redirect_valid, 64'h1);
    next_cycle();
    idle();
    sample();
    check_eq("t2_rv_off", ifc.redirect_valid, 64'h0);
    check_eq("t2_rpc_hold", ifc.redirect_pc, 64'hBFC0_0100);
    next_cycle();

    // 3: branch while PC stalled -> held until first unstalled cycle
    ifc.stallreq_ic = 1'b1;
    exp_redir_q.push_back(32'h8000_0040);
    for (int i = 1; i <= 4; i++) begin
      ifc.br_e      = (i == 1) || (i == 3);
      ifc.br_target = (i == 1) ? 32'h8000_0040 : 32'hDEAD_0000;
      sample();
      check_eq("t3_hold_rv", ifc.redirect_valid, 64'h0);
      check_eq("t3_stall", ifc.stall, 64'h03);
      next_cycle();
    end
    idle();
    sample();
    check_eq("t3_rv", ifc.redirect_valid, 64'h1);
    next_cycle();
    sample();
    check_eq("t3_rv_off", ifc.redirect_valid, 64'h0);
    check_eq("t3_cnt_ic", ifc.cnt_ic, 64'd4);
    next_cycle();

    // 4: exception -> freeze, then flush + redirect two cycles later
    ifc.excp_valid = 1'b1;
    ifc.excp_pc    = 32'hBFC0_0380;
    exp_redir_q.push_back(32'hBFC0_0380);
    sample();
    check_eq("t4_freeze", ifc.stall, 64'h3F);
    check_eq("t4_rv0", ifc.redirect_valid, 64'h0);
    next_cycle();
    idle();
    sample();
    check_eq("t4_flush_early", ifc.flush, 64'h0);
    check_eq("t4_rv1", ifc.redirect_valid, 64'h0);
    next_cycle();
    ifc.stallreq_ex = 1'b1;
    ifc.br_e        = 1'b1;
    ifc.br_target   = 32'h1234_0000;
    ifc.excp_valid  = 1'b1;
    ifc.excp_pc     = 32'h5555_0000;
    sample();
    check_eq("t4_flush", ifc.flush, 64'h1);
    check_eq("t4_rv2", ifc.redirect_valid, 64'h1);
    check_eq("t4_stall0", ifc.stall, 64'h0);
    next_cycle();
    idle();
    sample();
    check_eq("t4_flush_off", ifc.flush, 64'h0);
    check_eq("t4_rv3", ifc.redirect_valid, 64'h0);
    check_eq("t4_cnt_ex", ifc.cnt_ex, 64'd0);
    check_eq("t4_rpc_hold", ifc.redirect_pc, 64'hBFC0_0380);
    next_cycle();

    // 5: exception during pending branch -> branch target discarded
    ifc.stallreq_ic = 1'b1;
    ifc.br_e        = 1'b1;
    ifc.br_target   = 32'h8000_0080;
    sample();
    check_eq("t5_rv0", ifc.redirect_valid, 64'h0);
    next_cycle();
    ifc.br_e       = 1'b0;
    ifc.excp_valid = 1'b1;
    ifc.excp_pc    = 32'hBFC0_0200;
    exp_redir_q.push_back(32'hBFC0_0200);
    sample();
    check_eq("t5_freeze", ifc.stall, 64'h3F);
    next_cycle();
    idle();
    next_cycle();
    sample();
    check_eq("t5_flush", ifc.flush, 64'h1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("t5_no_branch", ifc.redirect_valid, 64'h0);
      next_cycle();
    end

    // 6: saturation and clear of cnt_ex
    ifc.cnt_clr = 1'b1;
    next_cycle();
    ifc.cnt_clr     = 1'b0;
    ifc.stallreq_ex = 1'b1;
    repeat (254) next_cycle();
    sample();
    check_eq("t6_cnt_fe", ifc.cnt_ex, 64'hFE);
    check_eq("t6_stall", ifc.stall, 64'h0F);
    repeat (3) next_cycle();
    sample();
    check_eq("t6_cnt_sat", ifc.cnt_ex, 64'hFF);
    ifc.cnt_clr = 1'b1;
    next_cycle();
    idle();
    sample();
    check_eq("t6_cnt_clr", ifc.cnt_ex, 64'h0);
    next_cycle();

    // Reset while a branch redirect is pending
    ifc.stallreq_ic = 1'b1;
    ifc.br_e        = 1'b1;
    ifc.br_target   = 32'h8000_0100;
    next_cycle();
    ifc.br_e = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check_eq("rst2_stall", ifc.stall, 64'h0);
    check_eq("rst2_flush", ifc.flush, 64'h0);
    check_eq("rst2_rv", ifc.redirect_valid, 64'h0);
    check_eq("rst2_rpc", ifc.redirect_pc, 64'h0);
    check_eq("rst2_cnt_ic", ifc.cnt_ic, 64'h0);
    idle();
    next_cycle();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("rst2_no_redir", ifc.redirect_valid, 64'h0);
      next_cycle();
    end

    check_eq("sb_empty", exp_redir_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 6-stage MIPS core (pc, ic, id, ex, mem, wb).
- Merges per-stage stall requests into the shared stall bus that every stage register consumes.
- Sequences exception flush and PC redirect, and holds a branch redirect while the PC stage is stalled.
- Keeps saturating per-cause stall counters for performance analysis.

Parameters:
- PC_W, 32, width of PC and redirect target.
- CNT_W, 32, width of each stall-cause counter.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous reset, active-low.
- stallreq_ic  in  1  icache miss or not-ready.
- stallreq_id  in  1  load-use hazard from decoder.
- stallreq_ex  in  1  multi-cycle div/mul busy.
- stallreq_mem  in  1  dcache miss or not-ready.
- br_e  in  1  branch taken, resolved this cycle.
- br_target  in  PC_W  branch target, valid with br_e.
- excp_valid  in  1  exception committed in mem stage.
- excp_pc  in  PC_W  handler/return target, valid with excp_valid.
- cnt_clr  in  1  synchronous clear of all counters.
- stall  out  6  StallBus; bit0 = pc … bit5 = wb; Stop=1, NoStop=0.
- flush  out  1  kill all in-flight stage registers.
- redirect_valid  out  1  PC must load redirect_pc this cycle.
- redirect_pc  out  PC_W  next fetch address.
- cnt_ic, cnt_id, cnt_ex, cnt_mem  out  CNT_W each  stall cycles attributed to each cause.

Behaviour:
- Reset (resetn=0, async): state=RUN, pending cleared, all counters 0, stall=0, flush=0, redirect_valid=0, redirect_pc=0.
- Stall vector in RUN/WAIT_REDIR (combinational, highest requesting stage wins):
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - ic → 6'b000011
  - none → 0
- Stage contract: a stage holds when stall[k]=Stop. It inserts a bubble when stall[k]=Stop and stall[k+1]=NoStop.
- States: RUN, WAIT_REDIR, EXCP, FLUSH.
- RUN:
  - excp_valid=1 → stall=6'b111111 this cycle; latch excp_pc; next=EXCP.
  - Else if br_e and stall[0]=NoStop → redirect_valid=1, redirect_pc=br_target this cycle (zero latency); stay RUN.
  - Else if br_e and stall[0]=Stop → latch br_target into pending; next=WAIT_REDIR.
- WAIT_REDIR:
  - stall computed normally.
  - First cycle with stall[0]=NoStop → redirect_valid=1, redirect_pc=pending; next=RUN.
  - br_e during WAIT_REDIR is ignored; pending is unchanged.
  - excp_valid has priority: pending is discarded; behaves as the RUN exception case.
- EXCP: always one cycle; next=FLUSH. (The freeze stall was issued in the entry cycle.)
- FLUSH (exactly 1 cycle):
  - flush=1, redirect_valid=1, redirect_pc=latched excp_pc, stall=0.
  - All stallreq_*, br_e and excp_valid inputs are ignored.
  - next=RUN.
- Latency:
  - exception → flush/redirect: 2 cycles after the excp_valid cycle (excp_valid cycle → EXCP → FLUSH).
  - branch (PC not stalled) → redirect: 0 cycles.
- redirect_valid is never high for 2 consecutive cycles from a single event. redirect_pc holds its last value when redirect_valid=0.
- Counters:
  - In RUN/WAIT_REDIR, the counter of the winning cause increments by 1 per cycle; lower-priority simultaneous requests are not counted.
  - Counters saturate at all-ones.
  - cnt_clr clears all counters and wins over increment.
  - Counters do not increment in EXCP/FLUSH.
- Reset mid-operation: pending redirect and latched exception PC are discarded; there is no redirect after reset release.

Decomposition:
- defines.vh gains:
  - StallBus width.
  - Stop/NoStop.
  - STALL_NONE, STALL_IC, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL vector constants.
  - State encodings PC_RUN, PC_WAIT_REDIR, PC_EXCP, PC_FLUSH.
- One sub-module: sat_cnt (CNT_W, inc, clr, async active-low reset), instantiated 4×.

Test Plan:
1. stallreq_id=1 and stallreq_mem=1 in same cycle, 3 cycles → stall=6'b011111 each cycle; cnt_mem=3, cnt_id=0.
2. br_e=1, br_target=32'hBFC0_0100, no stalls → same cycle redirect_valid=1, redirect_pc=32'hBFC0_0100; next cycle redirect_valid=0.
3. stallreq_ic held 4 cycles; br_e=1 (target 32'h8000_0040) in cycle 1 → redirect_valid=0 for cycles 1–4; redirect_valid=1 with 32'h8000_0040 in cycle 5 (first unstalled); exactly one pulse.
4. excp_valid=1, excp_pc=32'hBFC0_0380 in cycle t → stall=6'b111111 at t; flush=1, redirect_valid=1, redirect_pc=32'hBFC0_0380 at t+2; stall=0 at t+2 even with stallreq_ex=1.
5. Pending branch (case 3 setup), excp_valid in cycle 2 → branch target never issued; only the exception redirect appears.
6. Force cnt_ex to all-ones minus 1, hold stallreq_ex 3 cycles → cnt_ex saturates at all-ones; cnt_clr=1 → 0 next cycle. Assert resetn=0 mid-WAIT_REDIR → all outputs 0 immediately, no redirect after release.
